// File: rtl/rt_mem_pkg.sv
// Shared definitions for the ray-tracing memory port: bus widths common with
// mem_main and the per-port arbiter state encoding.
package rt_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rt_mem_port_arbiter_rr.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping around. Holds no state; the owner keeps last-grant.
module rr_arbiter #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  localparam int PW = IW + 1;

  logic [PW-1:0] pos_s;
  logic          hit_s;

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    pos_s   = '0;
    hit_s   = 1'b0;
    for (int k = N; k >= 1; k--) begin
      pos_s   = {1'b0, last} + PW'(k);
      pos_s   = (pos_s >= PW'(N)) ? (pos_s - PW'(N)) : pos_s;
      hit_s   = req[pos_s[IW-1:0]];
      gnt_idx = hit_s ? pos_s[IW-1:0] : gnt_idx;
      any     = hit_s | any;
    end
    gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/rt_mem_port_arbiter.sv
// Shares one mem_main RT port among NUM_REQ requesters: round-robin accept,
// one-cycle issue, then read-data return guarded by a timeout watchdog.
module rt_mem_port_arbiter
  import rt_mem_pkg::*;
#(
  parameter int NUM_REQ    = 8,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*MEM_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*MEM_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [MEM_DATA_W-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [MEM_ADDR_W-1:0]         mem_addr,
  output logic [MEM_DATA_W-1:0]         mem_wdata,
  input  logic                          mem_rdy,
  input  logic [MEM_DATA_W-1:0]         mem_rdata,
  output logic                          busy,
  output logic                          timeout_flag,
  input  logic                          timeout_clr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  arb_state_t            state_r;
  logic [IW-1:0]         last_r;
  logic [IW-1:0]         id_r;
  logic                  we_r;
  logic [MEM_ADDR_W-1:0] addr_r;
  logic [MEM_DATA_W-1:0] wdata_r;
  logic [CW-1:0]         cnt_r;

  logic [NUM_REQ-1:0]    req_ready_r;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [MEM_DATA_W-1:0] rsp_data_r;
  logic                  rsp_err_r;
  logic                  mem_re_r;
  logic                  mem_we_r;
  logic [MEM_ADDR_W-1:0] mem_addr_r;
  logic [MEM_DATA_W-1:0] mem_wdata_r;
  logic                  busy_r;
  logic                  timeout_flag_r;

  logic [NUM_REQ-1:0]    gnt_onehot_s;
  logic [IW-1:0]         gnt_idx_s;
  logic                  any_s;
  logic [NUM_REQ-1:0]    id_onehot_s;
  logic [MEM_ADDR_W-1:0] sel_addr_s;
  logic [MEM_DATA_W-1:0] sel_wdata_s;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last       (last_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (any_s)
  );

  assign id_onehot_s = NUM_REQ'(1) << id_r;
  assign sel_addr_s  = req_addr[gnt_idx_s * MEM_ADDR_W +: MEM_ADDR_W];
  assign sel_wdata_s = req_wdata[gnt_idx_s * MEM_DATA_W +: MEM_DATA_W];

  // Access sequencer: accept -> issue -> (read) wait, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      last_r         <= IW'(NUM_REQ - 1);
      id_r           <= '0;
      we_r           <= 1'b0;
      addr_r         <= '0;
      wdata_r        <= '0;
      cnt_r          <= '0;
      req_ready_r    <= '0;
      rsp_valid_r    <= '0;
      rsp_data_r     <= '0;
      rsp_err_r      <= 1'b0;
      mem_re_r       <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= '0;
      busy_r         <= 1'b0;
      timeout_flag_r <= 1'b0;
    end else begin
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      rsp_err_r   <= 1'b0;
      mem_re_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (timeout_clr) begin
        timeout_flag_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (any_s) begin
            id_r        <= gnt_idx_s;
            we_r        <= req_we[gnt_idx_s];
            addr_r      <= sel_addr_s;
            wdata_r     <= sel_wdata_s;
            req_ready_r <= gnt_onehot_s;
            last_r      <= gnt_idx_s;
            state_r     <= ISSUE;
            busy_r      <= 1'b1;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ISSUE: begin
          mem_re_r    <= ~we_r;
          mem_we_r    <= we_r;
          mem_addr_r  <= addr_r;
          mem_wdata_r <= wdata_r;
          cnt_r       <= '0;
          if (we_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= WAIT_RD;
            busy_r  <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (mem_rdy) begin
            rsp_valid_r <= id_onehot_s;
            rsp_data_r  <= mem_rdata;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            rsp_valid_r    <= id_onehot_s;
            rsp_data_r     <= '0;
            rsp_err_r      <= 1'b1;
            timeout_flag_r <= 1'b1;
            state_r        <= IDLE;
            busy_r         <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_err      = rsp_err_r;
  assign mem_re       = mem_re_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign busy         = busy_r;
  assign timeout_flag = timeout_flag_r;

endmodule

// File: tb/tb_rt_mem_port_arbiter.sv
// Bench for rt_mem_port_arbiter: a directed vector table, corner-case sequences
// and random traffic, all checked against a transaction-timeline reference model.
module tb_rt_mem_port_arbiter;
  import rt_mem_pkg::*;

  localparam int N  = 8;
  localparam int TO = 12;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N-1:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [N*32-1:0]    req_addr;
  logic [N*128-1:0]   req_wdata;
  logic [127:0]       rsp_data, mem_wdata, mem_rdata;
  logic [31:0]        mem_addr;
  logic               rsp_err, mem_re, mem_we, mem_rdy, busy, timeout_flag, timeout_clr;

  always #5 clk = ~clk;

  rt_mem_port_arbiter #(.NUM_REQ(N), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .busy(busy),
    .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: when the arbiter next looks at requests, and the open transaction.
  int           free_at, op_cycle, wait_start, exp_last;
  bit           waiting;
  logic         exp_flag;
  int           t_id;
  logic         t_we;
  logic [31:0]  t_addr, exp_maddr;
  logic [127:0] t_wdata, exp_mwdata;

  // Memory responder.
  int           pend, rd_delay;
  logic [31:0]  rd_addr;
  logic         stray;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_ready;
    logic         exp_we;
    logic [31:0]  exp_addr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    logic [N-1:0] e_ready, e_rv;
    logic         e_re, e_we, e_err, to_now, fire;
    logic [127:0] e_data;
    @(posedge clk);
    cyc++;
    #1;
    e_ready = '0; e_rv = '0; e_re = 1'b0; e_we = 1'b0; e_err = 1'b0;
    to_now = 1'b0; e_data = '0;
    if (cyc == op_cycle) begin
      e_re = ~t_we;
      e_we = t_we;
      exp_maddr = t_addr;
      exp_mwdata = t_wdata;
      if (t_we) free_at = cyc + 1;
      else begin
        waiting = 1'b1;
        wait_start = cyc + 1;
      end
    end else if (waiting && cyc >= wait_start) begin
      if (mem_rdy) begin
        e_rv = N'(1) << t_id;
        e_data = mem_rdata;
        waiting = 1'b0;
        free_at = cyc + 1;
      end else if (cyc - wait_start + 1 == TO) begin
        e_rv = N'(1) << t_id;
        e_err = 1'b1;
        to_now = 1'b1;
        waiting = 1'b0;
        free_at = cyc + 1;
      end
    end else if (cyc == free_at) begin
      if (req_valid != '0) begin
        t_id = pick(req_valid, exp_last);
        e_ready = N'(1) << t_id;
        exp_last = t_id;
        t_we = req_we[t_id];
        t_addr = req_addr[32*t_id +: 32];
        t_wdata = req_wdata[128*t_id +: 128];
        op_cycle = cyc + 1;
        free_at = -1;
      end else begin
        free_at = cyc + 1;
      end
    end
    if (to_now) exp_flag = 1'b1;
    else if (timeout_clr) exp_flag = 1'b0;

    chk("req_ready", req_ready, e_ready);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, exp_maddr);
    chk("mem_wdata", mem_wdata, exp_mwdata);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_err", rsp_err, e_err);
    if (e_rv != '0) chk("rsp_data", rsp_data, e_data);
    chk("busy", busy, (free_at != cyc + 1));
    chk("timeout_flag", timeout_flag, exp_flag);

    fire = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) fire = 1'b1;
    end
    if (mem_re) begin
      rd_addr = mem_addr;
      if (rd_delay == 0) fire = 1'b1;
      else if (rd_delay > 0) pend = rd_delay;
    end
    mem_rdy = fire | stray;
    mem_rdata = fire ? data_of(rd_addr) : {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_flag", timeout_flag, 1'b0);
    req_valid = '0; timeout_clr = 1'b0; stray = 1'b0; pend = 0; mem_rdy = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
    free_at = cyc + 1; waiting = 1'b0; op_cycle = -1; exp_last = N - 1;
    exp_flag = 1'b0; exp_maddr = '0; exp_mwdata = '0;
  endtask

  task automatic wait_idle();
    req_valid = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (!busy) break;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int c = 0; c < TO + 20; c++) begin
      tick();
      if (rsp_valid != '0) begin
        lat = c;
        return;
      end
    end
  endtask

  initial begin
    int order[$];
    int rsp3, g5, lat, sv;

    req_valid = '0; req_we = '0; timeout_clr = 1'b0; mem_rdy = 1'b0; mem_rdata = '0;
    stray = 1'b0; pend = 0; rd_delay = 2; rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = 32'h10 + 32'h100 * i;
      req_wdata[128*i +: 128] = 128'hA5 + 128'(i);
    end
    tbl[0] = '{8'h01, 8'h01, 1'b1, 32'h010};
    tbl[1] = '{8'hFF, 8'h02, 1'b1, 32'h110};
    tbl[2] = '{8'h81, 8'h80, 1'b1, 32'h710};
    tbl[3] = '{8'h81, 8'h01, 1'b1, 32'h010};
    tbl[4] = '{8'h0C, 8'h04, 1'b1, 32'h210};
    tbl[5] = '{8'h08, 8'h08, 1'b1, 32'h310};
    tbl[6] = '{8'h04, 8'h04, 1'b1, 32'h210};
    tbl[7] = '{8'h00, 8'h00, 1'b0, 32'h210};
    tbl[8] = '{8'hFE, 8'h08, 1'b1, 32'h310};
    tbl[9] = '{8'h20, 8'h20, 1'b1, 32'h510};

    do_reset();

    // Directed write vectors: grant pulse, then the write one cycle later.
    req_we = '1;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].req;
      tick();
      chk("tbl_ready", req_ready, tbl[i].exp_ready);
      req_valid = '0;
      tick();
      chk("tbl_mem_we", mem_we, tbl[i].exp_we);
      chk("tbl_mem_addr", mem_addr, tbl[i].exp_addr);
    end

    // All requesters reading: strict rotation starting at 0 after reset.
    do_reset();
    req_we = '0; rd_delay = 2; req_valid = 8'hFF;
    for (int c = 0; c < 200 && order.size() < 9; c++) begin
      tick();
      if (req_ready != '0) order.push_back($clog2(req_ready));
      if (rsp_valid != '0)
        chk("rr_rsp_data", rsp_data, data_of(32'h10 + 32'h100 * $clog2(rsp_valid)));
    end
    chk("rr_count", order.size(), 9);
    foreach (order[i]) chk("rr_order", order[i], i % N);
    wait_idle();

    // Slow read from 3 blocks requester 5 until the response is delivered.
    rd_delay = 10; rsp3 = -1; g5 = -1;
    req_valid = 8'h08;
    tick();
    req_valid = 8'h20;
    for (int c = 0; c < 40 && g5 < 0; c++) begin
      tick();
      if (rsp_valid[3]) rsp3 = cyc;
      if (req_ready[5]) g5 = cyc;
    end
    chk("blk_rsp3_seen", (rsp3 > 0), 1'b1);
    chk("blk_gnt5_cycle", g5, rsp3 + 1);
    wait_idle();

    // Read timeout, then the sticky flag and its clear.
    rd_delay = -1; req_valid = 8'h01;
    tick();
    req_valid = '0;
    wait_rsp(lat);
    chk("to_latency", lat, TO);
    chk("to_err", rsp_err, 1'b1);
    chk("to_data", rsp_data, '0);
    repeat (3) tick();
    chk("to_flag_sticky", timeout_flag, 1'b1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("to_flag_cleared", timeout_flag, 1'b0);

    // Clear held through a new timeout: the set wins.
    timeout_clr = 1'b1; req_valid = 8'h02;
    tick();
    req_valid = '0;
    wait_rsp(lat);
    chk("to_set_wins", timeout_flag, 1'b1);
    tick();
    chk("to_clr_after", timeout_flag, 1'b0);
    timeout_clr = 1'b0;
    wait_idle();

    // Data on the timeout cycle wins; data one cycle later is a dropped stray.
    rd_delay = TO - 1; req_valid = 8'h04;
    tick();
    req_valid = '0;
    wait_rsp(lat);
    chk("coinc_err", rsp_err, 1'b0);
    chk("coinc_data", rsp_data, data_of(32'h210));
    wait_idle();
    rd_delay = TO; req_valid = 8'h08;
    tick();
    req_valid = '0;
    wait_rsp(lat);
    chk("late_err", rsp_err, 1'b1);
    sv = 0;
    stray = 1'b1;
    repeat (4) begin
      tick();
      if (rsp_valid != '0) sv++;
    end
    stray = 1'b0;
    chk("stray_no_rsp", sv, 0);

    // Reset in the middle of a read: nothing stale afterwards, 0 wins first.
    rd_delay = -1; req_valid = 8'h10;
    tick();
    req_valid = '0;
    repeat (3) tick();
    do_reset();
    rd_delay = 1; req_valid = 8'hFF;
    tick();
    chk("post_rst_first", req_ready, 8'h01);
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_we = N'($urandom);
      req_addr[32*$urandom_range(0, N-1) +: 32] = $urandom;
      req_wdata[128*$urandom_range(0, N-1) +: 128] = {$urandom, $urandom, $urandom, $urandom};
      timeout_clr = ($urandom_range(0, 7) == 0);
      stray = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) rd_delay = -1;
      else rd_delay = $urandom_range(0, TO + 2);
      tick();
    end
    timeout_clr = 1'b0; stray = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
